id_ex_stage: RTL and testbench



---
 rtl/cpu_pkg.sv | 19 +
 rtl/id_ex_stage_if.sv | 64 ++++++
 rtl/id_ex_stage_fwd_sel.sv | 32 +++
 rtl/id_ex_stage.sv | 158 +++++++++++++++
 tb/tb_id_ex_stage.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared datapath widths and ALU opcode constants
package cpu_pkg;

    localparam int XLEN   = 32;
    localparam int REG_AW = 5;
    localparam int ALU_OPW = 4;

    typedef logic [ALU_OPW-1:0] alu_op_t;

    localparam alu_op_t ALU_NOP   = 4'b0000;
    localparam alu_op_t ALU_ADDU  = 4'b0001;
    localparam alu_op_t ALU_SUBU  = 4'b0010;
    localparam alu_op_t ALU_LUI   = 4'b0011;
    localparam alu_op_t ALU_ORI   = 4'b0100;
    localparam alu_op_t ALU_PASSA = 4'b0101;
    // jal: the ALU returns B+4, so B must carry the instruction's own PC
    localparam alu_op_t ALU_JAL   = 4'b1001;

endpackage

// File: rtl/id_ex_stage_if.sv
// rtl/id_ex_stage_if.sv - ID-side inputs, forward sources and EX-side outputs of the ID/EX stage
interface id_ex_stage_if #(
    parameter int XLEN   = cpu_pkg::XLEN,
    parameter int REG_AW = cpu_pkg::REG_AW
);
    logic              id_valid;
    logic              id_ready;
    logic [XLEN-1:0]   id_pc;
    logic [REG_AW-1:0] id_rs;
    logic [REG_AW-1:0] id_rt;
    logic [REG_AW-1:0] id_rd;
    logic              id_uses_rs;
    logic              id_uses_rt;
    logic [XLEN-1:0]   id_rs_val;
    logic [XLEN-1:0]   id_rt_val;
    logic [XLEN-1:0]   id_imm;
    logic [3:0]        id_alu_op;
    logic              id_alusrc_imm;
    logic              id_reg_write;
    logic              id_mem_read;
    logic              id_mem_write;
    logic              id_is_branch;
    logic              flush;

    logic [REG_AW-1:0] exmem_rd;
    logic              exmem_reg_write;
    logic [XLEN-1:0]   exmem_result;
    logic [REG_AW-1:0] memwb_rd;
    logic              memwb_reg_write;
    logic [XLEN-1:0]   memwb_result;

    logic              ex_valid;
    logic [XLEN-1:0]   ex_a;
    logic [XLEN-1:0]   ex_b;
    logic [3:0]        ex_op;
    logic [XLEN-1:0]   ex_pc;
    logic [XLEN-1:0]   ex_store_data;
    logic [REG_AW-1:0] ex_rd;
    logic              ex_reg_write;
    logic              ex_mem_read;
    logic              ex_mem_write;
    logic              ex_is_branch;
    logic              stall;

    modport master (
        output id_valid, id_pc, id_rs, id_rt, id_rd, id_uses_rs, id_uses_rt,
               id_rs_val, id_rt_val, id_imm, id_alu_op, id_alusrc_imm,
               id_reg_write, id_mem_read, id_mem_write, id_is_branch, flush,
               exmem_rd, exmem_reg_write, exmem_result,
               memwb_rd, memwb_reg_write, memwb_result,
        input  id_ready, ex_valid, ex_a, ex_b, ex_op, ex_pc, ex_store_data, ex_rd,
               ex_reg_write, ex_mem_read, ex_mem_write, ex_is_branch, stall
    );

    modport slave (
        input  id_valid, id_pc, id_rs, id_rt, id_rd, id_uses_rs, id_uses_rt,
               id_rs_val, id_rt_val, id_imm, id_alu_op, id_alusrc_imm,
               id_reg_write, id_mem_read, id_mem_write, id_is_branch, flush,
               exmem_rd, exmem_reg_write, exmem_result,
               memwb_rd, memwb_reg_write, memwb_result,
        output id_ready, ex_valid, ex_a, ex_b, ex_op, ex_pc, ex_store_data, ex_rd,
               ex_reg_write, ex_mem_read, ex_mem_write, ex_is_branch, stall
    );
endinterface

// File: rtl/id_ex_stage_fwd_sel.sv
// rtl/id_ex_stage_fwd_sel.sv - EX/MEM over MEM/WB over captured value, register 0 pinned to zero
module fwd_sel #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5
) (
    input  logic [REG_AW-1:0] idx_i,
    input  logic [XLEN-1:0]   cap_i,
    input  logic [REG_AW-1:0] exmem_rd_i,
    input  logic              exmem_we_i,
    input  logic [XLEN-1:0]   exmem_res_i,
    input  logic [REG_AW-1:0] memwb_rd_i,
    input  logic              memwb_we_i,
    input  logic [XLEN-1:0]   memwb_res_i,
    output logic [XLEN-1:0]   data_o
);
    logic exmem_hit;
    logic memwb_hit;

    assign exmem_hit = exmem_we_i && (exmem_rd_i != '0) && (exmem_rd_i == idx_i);
    assign memwb_hit = memwb_we_i && (memwb_rd_i != '0) && (memwb_rd_i == idx_i);

    always_comb begin
        data_o = cap_i;
        if (idx_i == '0) begin
            data_o = '0;
        end else if (exmem_hit) begin
            data_o = exmem_res_i;
        end else if (memwb_hit) begin
            data_o = memwb_res_i;
        end
    end
endmodule

// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX pipeline register with operand forwarding and load-use stall
module id_ex_stage #(
    parameter int XLEN   = cpu_pkg::XLEN,
    parameter int REG_AW = cpu_pkg::REG_AW
) (
    input logic         clk,
    input logic         rst_n,
    id_ex_stage_if.slave bus
);
    import cpu_pkg::ALU_NOP;
    import cpu_pkg::ALU_JAL;

    logic              valid_q,     valid_d;
    logic [XLEN-1:0]   pc_q,        pc_d;
    logic [REG_AW-1:0] rs_q,        rs_d;
    logic [REG_AW-1:0] rt_q,        rt_d;
    logic [REG_AW-1:0] rd_q,        rd_d;
    logic [XLEN-1:0]   rs_val_q,    rs_val_d;
    logic [XLEN-1:0]   rt_val_q,    rt_val_d;
    logic [XLEN-1:0]   imm_q,       imm_d;
    logic [3:0]        op_q,        op_d;
    logic              alusrc_imm_q, alusrc_imm_d;
    logic              reg_write_q, reg_write_d;
    logic              mem_read_q,  mem_read_d;
    logic              mem_write_q, mem_write_d;
    logic              is_branch_q, is_branch_d;

    logic              stall_w;
    logic              bubble_w;
    logic [XLEN-1:0]   fwd_rs;
    logic [XLEN-1:0]   fwd_rt;

    // A load in EX cannot forward yet; any ID reader of its destination must wait one cycle
    always_comb begin
        stall_w = valid_q && mem_read_q && (rd_q != '0) &&
                  ((bus.id_uses_rs && (bus.id_rs == rd_q)) ||
                   (bus.id_uses_rt && (bus.id_rt == rd_q))) &&
                  bus.id_valid && !bus.flush;
    end

    assign bus.stall    = stall_w;
    assign bus.id_ready = !stall_w;
    assign bubble_w     = bus.flush || stall_w;

    always_comb begin
        valid_d      = bus.id_valid;
        pc_d         = bus.id_pc;
        rs_d         = bus.id_rs;
        rt_d         = bus.id_rt;
        rd_d         = bus.id_rd;
        // The register file is written late in the cycle, so WB data must bypass a stale read
        rs_val_d     = (bus.memwb_reg_write && (bus.memwb_rd != '0) && (bus.memwb_rd == bus.id_rs))
                       ? bus.memwb_result : bus.id_rs_val;
        rt_val_d     = (bus.memwb_reg_write && (bus.memwb_rd != '0) && (bus.memwb_rd == bus.id_rt))
                       ? bus.memwb_result : bus.id_rt_val;
        imm_d        = bus.id_imm;
        op_d         = bus.id_alu_op;
        alusrc_imm_d = bus.id_alusrc_imm;
        reg_write_d  = bus.id_reg_write;
        mem_read_d   = bus.id_mem_read;
        mem_write_d  = bus.id_mem_write;
        is_branch_d  = bus.id_is_branch;
        if (bubble_w) begin
            valid_d      = 1'b0;
            pc_d         = '0;
            rs_d         = '0;
            rt_d         = '0;
            rd_d         = '0;
            rs_val_d     = '0;
            rt_val_d     = '0;
            imm_d        = '0;
            op_d         = ALU_NOP;
            alusrc_imm_d = 1'b0;
            reg_write_d  = 1'b0;
            mem_read_d   = 1'b0;
            mem_write_d  = 1'b0;
            is_branch_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q      <= 1'b0;
            pc_q         <= '0;
            rs_q         <= '0;
            rt_q         <= '0;
            rd_q         <= '0;
            rs_val_q     <= '0;
            rt_val_q     <= '0;
            imm_q        <= '0;
            op_q         <= ALU_NOP;
            alusrc_imm_q <= 1'b0;
            reg_write_q  <= 1'b0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            is_branch_q  <= 1'b0;
        end else begin
            valid_q      <= valid_d;
            pc_q         <= pc_d;
            rs_q         <= rs_d;
            rt_q         <= rt_d;
            rd_q         <= rd_d;
            rs_val_q     <= rs_val_d;
            rt_val_q     <= rt_val_d;
            imm_q        <= imm_d;
            op_q         <= op_d;
            alusrc_imm_q <= alusrc_imm_d;
            reg_write_q  <= reg_write_d;
            mem_read_q   <= mem_read_d;
            mem_write_q  <= mem_write_d;
            is_branch_q  <= is_branch_d;
        end
    end

    fwd_sel #(.XLEN(XLEN), .REG_AW(REG_AW)) u_fwd_rs (
        .idx_i       (rs_q),
        .cap_i       (rs_val_q),
        .exmem_rd_i  (bus.exmem_rd),
        .exmem_we_i  (bus.exmem_reg_write),
        .exmem_res_i (bus.exmem_result),
        .memwb_rd_i  (bus.memwb_rd),
        .memwb_we_i  (bus.memwb_reg_write),
        .memwb_res_i (bus.memwb_result),
        .data_o      (fwd_rs)
    );

    fwd_sel #(.XLEN(XLEN), .REG_AW(REG_AW)) u_fwd_rt (
        .idx_i       (rt_q),
        .cap_i       (rt_val_q),
        .exmem_rd_i  (bus.exmem_rd),
        .exmem_we_i  (bus.exmem_reg_write),
        .exmem_res_i (bus.exmem_result),
        .memwb_rd_i  (bus.memwb_rd),
        .memwb_we_i  (bus.memwb_reg_write),
        .memwb_res_i (bus.memwb_result),
        .data_o      (fwd_rt)
    );

    always_comb begin
        bus.ex_b = fwd_rt;
        if (op_q == ALU_JAL) begin
            bus.ex_b = pc_q;
        end else if (alusrc_imm_q) begin
            bus.ex_b = imm_q;
        end
    end

    assign bus.ex_valid      = valid_q;
    assign bus.ex_a          = fwd_rs;
    assign bus.ex_op         = op_q;
    assign bus.ex_pc         = pc_q;
    assign bus.ex_store_data = fwd_rt;
    assign bus.ex_rd         = rd_q;
    assign bus.ex_reg_write  = reg_write_q;
    assign bus.ex_mem_read   = mem_read_q;
    assign bus.ex_mem_write  = mem_write_q;
    assign bus.ex_is_branch  = is_branch_q;
endmodule

// File: tb/tb_id_ex_stage.sv
// tb/tb_id_ex_stage.sv - directed and randomized self-checking bench for id_ex_stage
module tb_id_ex_stage;
    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;

    id_ex_stage_if #(.XLEN(32), .REG_AW(5)) bus ();

    id_ex_stage #(.XLEN(32), .REG_AW(5)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        bub;
        logic        valid;
        logic [31:0] pc, rsv, rtv, imm;
        logic [4:0]  rs, rt, rd;
        logic [3:0]  op;
        logic        src, rw, mr, mw, br;
    } rec_t;

    task automatic set_idle();
        bus.id_valid = 0; bus.id_pc = 0; bus.id_rs = 0; bus.id_rt = 0; bus.id_rd = 0;
        bus.id_uses_rs = 0; bus.id_uses_rt = 0; bus.id_rs_val = 0; bus.id_rt_val = 0;
        bus.id_imm = 0; bus.id_alu_op = 0; bus.id_alusrc_imm = 0; bus.id_reg_write = 0;
        bus.id_mem_read = 0; bus.id_mem_write = 0; bus.id_is_branch = 0; bus.flush = 0;
        bus.exmem_rd = 0; bus.exmem_reg_write = 0; bus.exmem_result = 0;
        bus.memwb_rd = 0; bus.memwb_reg_write = 0; bus.memwb_result = 0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 0;
        set_idle();
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if (bus.ex_valid !== 1'b0) begin $display("FAIL reset_hold_valid: got %b want 0", bus.ex_valid); n_err++; end
        n_cmp++; if (bus.stall !== 1'b0) begin $display("FAIL reset_hold_stall: got %b want 0", bus.stall); n_err++; end
        rst_n = 1;
        step();
        step();
        n_cmp++; if (bus.ex_valid !== 1'b0) begin $display("FAIL reset_valid: got %b want 0", bus.ex_valid); n_err++; end
        n_cmp++; if (bus.ex_op !== 4'b0000) begin $display("FAIL reset_op: got %h want 0", bus.ex_op); n_err++; end
        n_cmp++; if ({bus.ex_a, bus.ex_b, bus.ex_pc, bus.ex_store_data} !== 128'h0) begin
            $display("FAIL reset_data: a=%h b=%h pc=%h sd=%h want all 0", bus.ex_a, bus.ex_b, bus.ex_pc, bus.ex_store_data); n_err++; end
        n_cmp++; if ({bus.ex_rd, bus.ex_reg_write, bus.ex_mem_read, bus.ex_mem_write, bus.ex_is_branch} !== 9'h0) begin
            $display("FAIL reset_ctrl: rd=%0d rw=%b mr=%b mw=%b br=%b want 0", bus.ex_rd, bus.ex_reg_write, bus.ex_mem_read, bus.ex_mem_write, bus.ex_is_branch); n_err++; end
        n_cmp++; if (bus.stall !== 1'b0 || bus.id_ready !== 1'b1) begin
            $display("FAIL reset_stall: stall=%b id_ready=%b want 0/1", bus.stall, bus.id_ready); n_err++; end
    endtask

    task automatic test_forward_priority();
        set_idle(); step();
        bus.id_valid = 1; bus.id_alu_op = 4'b0001; bus.id_rs = 3; bus.id_rt = 4; bus.id_rd = 6;
        bus.id_uses_rs = 1; bus.id_uses_rt = 1; bus.id_rs_val = 32'h111; bus.id_rt_val = 32'h222; bus.id_reg_write = 1;
        step();
        set_idle();
        bus.exmem_rd = 3; bus.exmem_reg_write = 1; bus.exmem_result = 32'h10;
        #1;
        n_cmp++; if (bus.ex_a !== 32'h10) begin $display("FAIL fwd_exmem: ex_a=%h want 10", bus.ex_a); n_err++; end
        n_cmp++; if (bus.ex_b !== 32'h222) begin $display("FAIL fwd_none_rt: ex_b=%h want 222", bus.ex_b); n_err++; end
        bus.memwb_rd = 3; bus.memwb_reg_write = 1; bus.memwb_result = 32'h20;
        #1;
        n_cmp++; if (bus.ex_a !== 32'h10) begin $display("FAIL fwd_priority: ex_a=%h want 10", bus.ex_a); n_err++; end
        bus.exmem_reg_write = 0;
        #1;
        n_cmp++; if (bus.ex_a !== 32'h20) begin $display("FAIL fwd_memwb: ex_a=%h want 20", bus.ex_a); n_err++; end
    endtask

    task automatic test_load_use();
        set_idle(); step();
        bus.id_valid = 1; bus.id_alu_op = 4'b0001; bus.id_rs = 1; bus.id_uses_rs = 1; bus.id_rd = 5;
        bus.id_mem_read = 1; bus.id_reg_write = 1; bus.id_alusrc_imm = 1; bus.id_imm = 4;
        step();
        set_idle();
        bus.id_valid = 1; bus.id_alu_op = 4'b0010; bus.id_rs = 2; bus.id_rt = 5; bus.id_uses_rs = 1; bus.id_uses_rt = 1;
        bus.id_rs_val = 32'h7; bus.id_rt_val = 32'h999; bus.id_rd = 8; bus.id_reg_write = 1;
        #1;
        n_cmp++; if (bus.stall !== 1'b1 || bus.id_ready !== 1'b0) begin
            $display("FAIL loaduse_stall: stall=%b id_ready=%b want 1/0", bus.stall, bus.id_ready); n_err++; end
        step();
        n_cmp++; if (bus.ex_valid !== 1'b0 || bus.ex_op !== 4'b0000 || bus.ex_rd !== 5'd0 || bus.ex_reg_write !== 1'b0 || bus.ex_mem_read !== 1'b0) begin
            $display("FAIL loaduse_bubble: valid=%b op=%h rd=%0d rw=%b mr=%b want all 0", bus.ex_valid, bus.ex_op, bus.ex_rd, bus.ex_reg_write, bus.ex_mem_read); n_err++; end
        n_cmp++; if (bus.stall !== 1'b0) begin $display("FAIL loaduse_release: stall=%b want 0", bus.stall); n_err++; end
        bus.exmem_rd = 5; bus.exmem_reg_write = 1; bus.exmem_result = 0;
        step();
        set_idle();
        bus.memwb_rd = 5; bus.memwb_reg_write = 1; bus.memwb_result = 32'hABC;
        #1;
        n_cmp++; if (bus.ex_valid !== 1'b1 || bus.ex_op !== 4'b0010 || bus.ex_rd !== 5'd8) begin
            $display("FAIL loaduse_enter: valid=%b op=%h rd=%0d want 1/2/8", bus.ex_valid, bus.ex_op, bus.ex_rd); n_err++; end
        n_cmp++; if (bus.ex_a !== 32'h7 || bus.ex_b !== 32'hABC || bus.ex_store_data !== 32'hABC) begin
            $display("FAIL loaduse_fwd: a=%h b=%h sd=%h want 7/abc/abc", bus.ex_a, bus.ex_b, bus.ex_store_data); n_err++; end
    endtask

    task automatic test_jal_ori_r0();
        set_idle(); step();
        bus.id_valid = 1; bus.id_alu_op = 4'b1001; bus.id_pc = 32'h40; bus.id_rd = 31; bus.id_reg_write = 1;
        bus.id_rt = 6; bus.id_rt_val = 32'h5A5A; bus.id_imm = 32'h1234;
        step();
        n_cmp++; if (bus.ex_op !== 4'b1001 || bus.ex_b !== 32'h40 || bus.ex_pc !== 32'h40) begin
            $display("FAIL jal_b: op=%h b=%h pc=%h want 9/40/40", bus.ex_op, bus.ex_b, bus.ex_pc); n_err++; end
        set_idle();
        bus.id_valid = 1; bus.id_alu_op = 4'b0100; bus.id_alusrc_imm = 1; bus.id_imm = 32'hFF;
        bus.id_rs = 2; bus.id_uses_rs = 1; bus.id_rs_val = 32'h1200; bus.id_rt = 9; bus.id_rt_val = 32'h3333; bus.id_rd = 9; bus.id_reg_write = 1;
        step();
        n_cmp++; if (bus.ex_b !== 32'hFF || bus.ex_a !== 32'h1200 || bus.ex_store_data !== 32'h3333) begin
            $display("FAIL ori_b: b=%h a=%h sd=%h want ff/1200/3333", bus.ex_b, bus.ex_a, bus.ex_store_data); n_err++; end
        set_idle();
        bus.id_valid = 1; bus.id_alu_op = 4'b0001; bus.id_rd = 4; bus.id_uses_rs = 1; bus.id_uses_rt = 1;
        step();
        bus.exmem_rd = 0; bus.exmem_reg_write = 1; bus.exmem_result = 32'hDEAD;
        bus.memwb_rd = 0; bus.memwb_reg_write = 1; bus.memwb_result = 32'hBEEF;
        #1;
        n_cmp++; if (bus.ex_a !== 32'h0 || bus.ex_b !== 32'h0) begin
            $display("FAIL r0_guard: a=%h b=%h want 0/0", bus.ex_a, bus.ex_b); n_err++; end
    endtask

    task automatic test_flush_stall_bypass();
        set_idle(); step();
        bus.id_valid = 1; bus.id_alu_op = 4'b0001; bus.id_rd = 7; bus.id_mem_read = 1; bus.id_reg_write = 1;
        step();
        set_idle();
        bus.id_valid = 1; bus.id_alu_op = 4'b0001; bus.id_rs = 7; bus.id_uses_rs = 1; bus.id_rd = 3; bus.id_reg_write = 1; bus.flush = 1;
        #1;
        n_cmp++; if (bus.stall !== 1'b0 || bus.id_ready !== 1'b1) begin
            $display("FAIL flush_wins: stall=%b id_ready=%b want 0/1", bus.stall, bus.id_ready); n_err++; end
        step();
        n_cmp++; if (bus.ex_valid !== 1'b0 || bus.ex_op !== 4'b0000 || bus.ex_reg_write !== 1'b0) begin
            $display("FAIL flush_bubble: valid=%b op=%h rw=%b want 0/0/0", bus.ex_valid, bus.ex_op, bus.ex_reg_write); n_err++; end
        set_idle();
        bus.id_valid = 1; bus.id_alu_op = 4'b0001; bus.id_rs = 7; bus.id_rt = 7; bus.id_uses_rs = 1; bus.id_uses_rt = 1;
        bus.id_rs_val = 32'h1; bus.id_rt_val = 32'h2; bus.id_rd = 9; bus.id_reg_write = 1;
        bus.memwb_rd = 7; bus.memwb_reg_write = 1; bus.memwb_result = 32'h55;
        step();
        set_idle();
        #1;
        n_cmp++; if (bus.ex_valid !== 1'b1 || bus.ex_a !== 32'h55 || bus.ex_store_data !== 32'h55) begin
            $display("FAIL wb_bypass: valid=%b a=%h sd=%h want 1/55/55", bus.ex_valid, bus.ex_a, bus.ex_store_data); n_err++; end
    endtask

    task automatic test_reset_mid_stall();
        set_idle(); step();
        bus.id_valid = 1; bus.id_alu_op = 4'b0001; bus.id_rd = 5; bus.id_mem_read = 1; bus.id_reg_write = 1;
        step();
        set_idle();
        bus.id_valid = 1; bus.id_alu_op = 4'b0001; bus.id_rs = 5; bus.id_uses_rs = 1; bus.id_rd = 6; bus.id_reg_write = 1;
        #1;
        n_cmp++; if (bus.stall !== 1'b1) begin $display("FAIL rst_pre_stall: stall=%b want 1", bus.stall); n_err++; end
        rst_n = 0;
        #1;
        n_cmp++; if (bus.ex_valid !== 1'b0 || bus.ex_mem_read !== 1'b0 || bus.ex_rd !== 5'd0 || bus.ex_reg_write !== 1'b0) begin
            $display("FAIL rst_async: valid=%b mr=%b rd=%0d rw=%b want 0", bus.ex_valid, bus.ex_mem_read, bus.ex_rd, bus.ex_reg_write); n_err++; end
        n_cmp++; if (bus.stall !== 1'b0 || bus.id_ready !== 1'b1) begin
            $display("FAIL rst_stall: stall=%b id_ready=%b want 0/1", bus.stall, bus.id_ready); n_err++; end
        rst_n = 1;
        set_idle();
        bus.id_valid = 1; bus.id_alu_op = 4'b0100; bus.id_alusrc_imm = 1; bus.id_imm = 32'hFF;
        bus.id_rs = 2; bus.id_uses_rs = 1; bus.id_rs_val = 32'h1200; bus.id_rd = 2; bus.id_reg_write = 1;
        step();
        n_cmp++; if (bus.ex_valid !== 1'b1 || bus.ex_op !== 4'b0100 || bus.ex_b !== 32'hFF || bus.ex_a !== 32'h1200 || bus.ex_rd !== 5'd2) begin
            $display("FAIL rst_first_capture: valid=%b op=%h b=%h a=%h rd=%0d want 1/4/ff/1200/2", bus.ex_valid, bus.ex_op, bus.ex_b, bus.ex_a, bus.ex_rd); n_err++; end
    endtask

    // Newest architectural value of a register as seen from EX right now
    function automatic logic [31:0] reg_now(input logic [4:0] idx, input logic [31:0] cap);
        if (idx == 0) return 32'h0;
        if (bus.exmem_reg_write && bus.exmem_rd == idx) return bus.exmem_result;
        if (bus.memwb_reg_write && bus.memwb_rd == idx) return bus.memwb_result;
        return cap;
    endfunction

    task automatic test_random();
        rec_t m, nm;
        logic exp_stall;
        logic [31:0] exp_b;
        logic [3:0] ops [6];
        ops = '{4'b0001, 4'b0010, 4'b0011, 4'b0100, 4'b0101, 4'b1001};
        set_idle();
        rst_n = 0; #2; rst_n = 1;
        m = '{bub: 1'b1, valid: 1'b0, op: 4'b0, rd: 5'd0, rw: 1'b0, mr: 1'b0, mw: 1'b0, br: 1'b0, default: '0};
        for (int c = 0; c < 400; c++) begin
            bus.id_valid = ($urandom_range(0, 3) != 0);
            bus.id_pc = $urandom; bus.id_rs = 5'($urandom_range(0, 7)); bus.id_rt = 5'($urandom_range(0, 7));
            bus.id_rd = 5'($urandom_range(0, 7)); bus.id_uses_rs = 1'($urandom_range(0, 1)); bus.id_uses_rt = 1'($urandom_range(0, 1));
            bus.id_rs_val = $urandom; bus.id_rt_val = $urandom; bus.id_imm = $urandom;
            bus.id_alu_op = ops[$urandom_range(0, 5)]; bus.id_alusrc_imm = 1'($urandom_range(0, 1));
            bus.id_reg_write = 1'($urandom_range(0, 1)); bus.id_mem_read = ($urandom_range(0, 2) == 0);
            bus.id_mem_write = 1'($urandom_range(0, 1)); bus.id_is_branch = 1'($urandom_range(0, 1));
            bus.flush = ($urandom_range(0, 7) == 0);
            bus.exmem_rd = 5'($urandom_range(0, 7)); bus.exmem_reg_write = 1'($urandom_range(0, 1)); bus.exmem_result = $urandom;
            bus.memwb_rd = 5'($urandom_range(0, 7)); bus.memwb_reg_write = 1'($urandom_range(0, 1)); bus.memwb_result = $urandom;
            #1;
            exp_stall = m.valid && m.mr && (m.rd != 0) &&
                        ((bus.id_uses_rs && bus.id_rs == m.rd) || (bus.id_uses_rt && bus.id_rt == m.rd)) &&
                        bus.id_valid && !bus.flush;
            n_cmp++; if (bus.stall !== exp_stall || bus.id_ready !== !exp_stall) begin
                $display("FAIL rnd_stall c=%0d: stall=%b id_ready=%b want %b", c, bus.stall, bus.id_ready, exp_stall); n_err++; end
            n_cmp++; if ({bus.ex_valid, bus.ex_op, bus.ex_rd, bus.ex_reg_write, bus.ex_mem_read, bus.ex_mem_write, bus.ex_is_branch} !==
                         {m.valid, m.op, m.rd, m.rw, m.mr, m.mw, m.br}) begin
                $display("FAIL rnd_ctrl c=%0d: v=%b op=%h rd=%0d ctl=%b%b%b%b want v=%b op=%h rd=%0d ctl=%b%b%b%b", c,
                         bus.ex_valid, bus.ex_op, bus.ex_rd, bus.ex_reg_write, bus.ex_mem_read, bus.ex_mem_write, bus.ex_is_branch,
                         m.valid, m.op, m.rd, m.rw, m.mr, m.mw, m.br); n_err++; end
            if (!m.bub) begin
                exp_b = (m.op == 4'b1001) ? m.pc : (m.src ? m.imm : reg_now(m.rt, m.rtv));
                n_cmp++; if (bus.ex_a !== reg_now(m.rs, m.rsv) || bus.ex_b !== exp_b ||
                             bus.ex_store_data !== reg_now(m.rt, m.rtv) || bus.ex_pc !== m.pc) begin
                    $display("FAIL rnd_data c=%0d: a=%h b=%h sd=%h pc=%h want a=%h b=%h sd=%h pc=%h", c,
                             bus.ex_a, bus.ex_b, bus.ex_store_data, bus.ex_pc,
                             reg_now(m.rs, m.rsv), exp_b, reg_now(m.rt, m.rtv), m.pc); n_err++; end
            end
            if (bus.flush || exp_stall) begin
                nm = '{bub: 1'b1, valid: 1'b0, op: 4'b0, rd: 5'd0, rw: 1'b0, mr: 1'b0, mw: 1'b0, br: 1'b0, default: '0};
            end else begin
                nm.bub = 0; nm.valid = bus.id_valid; nm.pc = bus.id_pc; nm.rs = bus.id_rs; nm.rt = bus.id_rt; nm.rd = bus.id_rd;
                nm.rsv = (bus.memwb_reg_write && bus.memwb_rd != 0 && bus.memwb_rd == bus.id_rs) ? bus.memwb_result : bus.id_rs_val;
                nm.rtv = (bus.memwb_reg_write && bus.memwb_rd != 0 && bus.memwb_rd == bus.id_rt) ? bus.memwb_result : bus.id_rt_val;
                nm.imm = bus.id_imm; nm.op = bus.id_alu_op; nm.src = bus.id_alusrc_imm;
                nm.rw = bus.id_reg_write; nm.mr = bus.id_mem_read; nm.mw = bus.id_mem_write; nm.br = bus.id_is_branch;
            end
            step();
            m = nm;
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst_n = 0;
        test_reset();
        test_forward_priority();
        test_load_use();
        test_jal_ori_r0();
        test_flush_stall_bypass();
        test_reset_mid_stall();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
